// File: rtl/decoder.sv
// RV32I decode stage: pops the iq head, decodes it and holds the result in one output register (latency 1).
// Define DC_ILLEGAL_CHECK_EN to flag illegal encodings as op 63; otherwise they decode as NOP.
module decoder #(
  parameter int XLEN = 32,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            is_empty_from_iq,
  input  logic [XLEN-1:0] instr_from_iq,
  input  logic [XLEN-1:0] pc_from_iq,
  input  logic            is_stall_from_rob,
  input  logic            is_exception_from_rob,
  output logic            is_receive_to_iq,
  output logic            is_valid_to_rob,
  output logic [OP_W-1:0] op_to_rob,
  output logic [4:0]      rd_to_rob,
  output logic [4:0]      rs1_to_rob,
  output logic [4:0]      rs2_to_rob,
  output logic [XLEN-1:0] imm_to_rob,
  output logic [XLEN-1:0] pc_to_rob,
  output logic            is_illegal_to_rob
);

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011, OPC_OP = 7'b0110011,
                         OPC_FENCE = 7'b0001111, OPC_SYS = 7'b1110011;

  logic [XLEN-1:0] ins;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign ins    = instr_from_iq;
  assign opc    = ins[6:0];
  assign f3     = ins[14:12];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_sh = {27'b0, ins[24:20]};

  logic [OP_W-1:0] op_d;
  logic [4:0]      rd_d, rs1_d, rs2_d;
  logic [XLEN-1:0] imm_d;
  logic            bad_d;

  // Fields are only filled on recognised encodings, so a bad opcode/funct3 leaves them all zero.
  always_comb begin
    op_d  = '0;
    rd_d  = '0;
    rs1_d = '0;
    rs2_d = '0;
    imm_d = '0;
    bad_d = 1'b0;
    case (opc)
      OPC_LUI:   begin op_d = OP_W'(1); rd_d = ins[11:7]; imm_d = imm_u; end
      OPC_AUIPC: begin op_d = OP_W'(2); rd_d = ins[11:7]; imm_d = imm_u; end
      OPC_JAL:   begin op_d = OP_W'(3); rd_d = ins[11:7]; imm_d = imm_j; end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          op_d = OP_W'(4); rd_d = ins[11:7]; rs1_d = ins[19:15]; imm_d = imm_i;
        end else bad_d = 1'b1;
      end
      OPC_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) bad_d = 1'b1;
        else begin
          case (f3)
            3'b000:  op_d = OP_W'(5);
            3'b001:  op_d = OP_W'(6);
            3'b100:  op_d = OP_W'(7);
            3'b101:  op_d = OP_W'(8);
            3'b110:  op_d = OP_W'(9);
            default: op_d = OP_W'(10);
          endcase
          rs1_d = ins[19:15]; rs2_d = ins[24:20]; imm_d = imm_b;
        end
      end
      OPC_LD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad_d = 1'b1;
        else begin
          op_d  = (f3[2]) ? OP_W'(14 + {2'b0, f3[0]}) : OP_W'(11 + {1'b0, f3[1:0]});
          rd_d  = ins[11:7]; rs1_d = ins[19:15]; imm_d = imm_i;
        end
      end
      OPC_ST: begin
        if (f3[2] || f3 == 3'b011) bad_d = 1'b1;
        else begin
          op_d  = OP_W'(16 + {1'b0, f3[1:0]});
          rs1_d = ins[19:15]; rs2_d = ins[24:20]; imm_d = imm_s;
        end
      end
      OPC_OPI: begin
        rd_d = ins[11:7]; rs1_d = ins[19:15]; imm_d = imm_i;
        case (f3)
          3'b000: op_d = OP_W'(19);
          3'b010: op_d = OP_W'(20);
          3'b011: op_d = OP_W'(21);
          3'b100: op_d = OP_W'(22);
          3'b110: op_d = OP_W'(23);
          3'b111: op_d = OP_W'(24);
          3'b001: begin op_d = OP_W'(25); imm_d = imm_sh; end
          default: begin op_d = ins[30] ? OP_W'(27) : OP_W'(26); imm_d = imm_sh; end
        endcase
      end
      OPC_OP: begin
        rd_d = ins[11:7]; rs1_d = ins[19:15]; rs2_d = ins[24:20];
        case (f3)
          3'b000: op_d = ins[30] ? OP_W'(29) : OP_W'(28);
          3'b001: op_d = OP_W'(30);
          3'b010: op_d = OP_W'(31);
          3'b011: op_d = OP_W'(32);
          3'b100: op_d = OP_W'(33);
          3'b101: op_d = ins[30] ? OP_W'(35) : OP_W'(34);
          3'b110: op_d = OP_W'(36);
          default: op_d = OP_W'(37);
        endcase
      end
      OPC_FENCE, OPC_SYS: op_d = '0;
      default: bad_d = 1'b1;
    endcase
  end

  logic [OP_W-1:0] op_c;
  logic            ill_c;
`ifdef DC_ILLEGAL_CHECK_EN
  logic need_f7;
  assign need_f7 = (opc == OPC_OP) || (opc == OPC_OPI && f3[1:0] == 2'b01);
  assign ill_c   = bad_d || (need_f7 && ins[31:25] != 7'h00 && ins[31:25] != 7'h20);
  assign op_c    = ill_c ? {OP_W{1'b1}} : op_d;
`else
  assign ill_c = 1'b0;
  assign op_c  = bad_d ? '0 : op_d;
`endif

  logic            valid_q, ill_q;
  logic [OP_W-1:0] op_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0] imm_q, pc_q;
  logic            pop;

  assign pop = rdy && !is_empty_from_iq && !is_exception_from_rob
               && (!valid_q || !is_stall_from_rob);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0; op_q <= '0; rd_q <= '0; rs1_q <= '0; rs2_q <= '0;
      imm_q <= '0; pc_q <= '0; ill_q <= 1'b0;
    end else if (rdy) begin
      if (is_exception_from_rob) begin
        valid_q <= 1'b0;
      end else if (pop) begin
        valid_q <= 1'b1;
        op_q    <= op_c;
        rd_q    <= ill_c ? 5'd0 : rd_d;
        rs1_q   <= ill_c ? 5'd0 : rs1_d;
        rs2_q   <= ill_c ? 5'd0 : rs2_d;
        imm_q   <= ill_c ? '0 : imm_d;
        pc_q    <= pc_from_iq;
        ill_q   <= ill_c;
      end else if (!(valid_q && is_stall_from_rob)) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign is_receive_to_iq  = pop;
  assign is_valid_to_rob   = valid_q;
  assign op_to_rob         = op_q;
  assign rd_to_rob         = rd_q;
  assign rs1_to_rob        = rs1_q;
  assign rs2_to_rob        = rs2_q;
  assign imm_to_rob        = imm_q;
  assign pc_to_rob         = pc_q;
  assign is_illegal_to_rob = ill_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: vector table replayed back-to-back and with random stall/freeze, plus stall/flush/reset sequences.
module tb_decoder;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b0;
  logic        is_empty_from_iq = 1'b1, is_stall_from_rob = 1'b0, is_exception_from_rob = 1'b0;
  logic [31:0] instr_from_iq = '0, pc_from_iq = '0;
  logic        is_receive_to_iq, is_valid_to_rob, is_illegal_to_rob;
  logic [5:0]  op_to_rob;
  logic [4:0]  rd_to_rob, rs1_to_rob, rs2_to_rob;
  logic [31:0] imm_to_rob, pc_to_rob;

  decoder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_empty_from_iq(is_empty_from_iq), .instr_from_iq(instr_from_iq), .pc_from_iq(pc_from_iq),
    .is_stall_from_rob(is_stall_from_rob), .is_exception_from_rob(is_exception_from_rob),
    .is_receive_to_iq(is_receive_to_iq), .is_valid_to_rob(is_valid_to_rob),
    .op_to_rob(op_to_rob), .rd_to_rob(rd_to_rob), .rs1_to_rob(rs1_to_rob), .rs2_to_rob(rs2_to_rob),
    .imm_to_rob(imm_to_rob), .pc_to_rob(pc_to_rob), .is_illegal_to_rob(is_illegal_to_rob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] instr, input int op, input int rd, input int rs1,
                      input int rs2, input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.op = 6'(op); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.imm = imm; v.ill = ill;
    vecs.push_back(v);
  endtask

  function automatic exp_t to_exp(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.op = v.op; e.rd = v.rd; e.rs1 = v.rs1; e.rs2 = v.rs2; e.imm = v.imm; e.pc = pc; e.ill = v.ill;
    return e;
  endfunction

  // One clock cycle: drive at negedge, check against the scoreboard, then advance the model.
  task automatic cyc(input logic r, input logic stall, input logic empty, input logic exc,
                     input vec_t v, input logic [31:0] pc, output logic popped);
    logic mv, exp_pop;
    @(negedge clk);
    rdy = r; is_stall_from_rob = stall; is_empty_from_iq = empty; is_exception_from_rob = exc;
    instr_from_iq = v.instr; pc_from_iq = pc;
    #1;
    mv      = (sb.size() != 0);
    exp_pop = r && !empty && !exc && (!mv || !stall);
    chk("receive", 32'(is_receive_to_iq), 32'(exp_pop));
    chk("valid", 32'(is_valid_to_rob), 32'(mv));
    if (mv) begin
      chk("op", 32'(op_to_rob), 32'(sb[0].op));
      chk("rd", 32'(rd_to_rob), 32'(sb[0].rd));
      chk("rs1", 32'(rs1_to_rob), 32'(sb[0].rs1));
      chk("rs2", 32'(rs2_to_rob), 32'(sb[0].rs2));
      chk("imm", imm_to_rob, sb[0].imm);
      chk("pc", pc_to_rob, sb[0].pc);
      chk("illegal", 32'(is_illegal_to_rob), 32'(sb[0].ill));
      if (r && (exc || !stall)) void'(sb.pop_front());
    end
    if (exp_pop) sb.push_back(to_exp(v, pc));
    popped = exp_pop;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(is_valid_to_rob), 32'd0);
    chk({tag, "_op"}, 32'(op_to_rob), 32'd0);
    chk({tag, "_regs"}, {17'd0, rd_to_rob, rs1_to_rob, rs2_to_rob}, 32'd0);
    chk({tag, "_imm"}, imm_to_rob, 32'd0);
    chk({tag, "_pc"}, pc_to_rob, 32'd0);
    chk({tag, "_illegal"}, 32'(is_illegal_to_rob), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  idle;
    logic  p;
    int    idx, budget;

    addv(32'h00500093, 19, 1, 0, 0, 32'd5, 1'b0);          // addi x1,x0,5
    addv(32'hFE000EE3, 5, 0, 0, 0, 32'hFFFFFFFC, 1'b0);    // beq x0,x0,-4
    addv(32'h123450B7, 1, 1, 0, 0, 32'h12345000, 1'b0);    // lui x1
    addv(32'h40208133, 29, 2, 1, 2, 32'd0, 1'b0);          // sub x2,x1,x2
    addv(32'h008000EF, 3, 1, 0, 0, 32'd8, 1'b0);           // jal x1,8
    addv(32'hFFF102E7, 4, 5, 2, 0, 32'hFFFFFFFF, 1'b0);    // jalr x5,-1(x2)
    addv(32'h01022183, 13, 3, 4, 0, 32'd16, 1'b0);         // lw x3,16(x4)
    addv(32'hFE532C23, 18, 0, 6, 5, 32'hFFFFFFF8, 1'b0);   // sw x5,-8(x6)
    addv(32'h40345393, 27, 7, 8, 0, 32'd3, 1'b0);          // srai x7,x8,3
    addv(32'hFFFFF517, 2, 10, 0, 0, 32'hFFFFF000, 1'b0);   // auipc x10
    addv(32'h00000073, 0, 0, 0, 0, 32'd0, 1'b0);           // ecall
    addv(32'h00D635B3, 32, 11, 12, 13, 32'd0, 1'b0);       // sltu x11,x12,x13
    addv(32'h00215083, 15, 1, 2, 0, 32'd2, 1'b0);          // lhu x1,2(x2)
    addv(32'h01F09093, 25, 1, 1, 0, 32'd31, 1'b0);         // slli x1,x1,31
    addv(32'h0020F863, 10, 0, 1, 2, 32'd16, 1'b0);         // bgeu x1,x2,16
`ifdef DC_ILLEGAL_CHECK_EN
    addv(32'hFFFFFFFF, 63, 0, 0, 0, 32'd0, 1'b1);
`else
    addv(32'hFFFFFFFF, 0, 0, 0, 0, 32'd0, 1'b0);
`endif
    idle = vecs[0];

    #1;
    chk_zero("reset");
    #20;
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) cyc(1'b1, 1'b0, 1'b0, 1'b0, vecs[i], 32'(i * 4), p);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);

    // Stall for three cycles with iq non-empty, then release.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, vecs[3], 32'h100, p);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, vecs[4], 32'h104, p);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, vecs[4], 32'h104, p);
    chk("stall_release_pop", 32'(p), 32'd1);

    // Global freeze holds a valid entry and blocks pops even under exception.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, vecs[5], 32'h108, p);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, vecs[5], 32'h108, p);

    // Flush with a valid entry and iq non-empty.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, vecs[5], 32'h108, p);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);
    chk("flush_cleared", 32'(is_valid_to_rob), 32'd0);

    // Random replay of the table under stall/freeze/empty noise.
    idx = 0; budget = 0;
    while (idx < vecs.size() && budget < 2000) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), vecs[idx], 32'h2000 + 32'(idx * 4), p);
      if (p) idx++;
      budget++;
    end
    chk("random_replay_done", 32'(idx), 32'(vecs.size()));
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-stream.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, vecs[2], 32'h300, p);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, vecs[3], 32'h304, p);
    #2 rst = 1'b1; is_empty_from_iq = 1'b1;
    #1;
    chk_zero("midreset");
    sb.delete();
    @(negedge clk) rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, vecs[1], 32'h400, p);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, idle, 32'h0, p);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
